// File: rtl/mp_app_dispatch_pkg.sv
// Shared definitions for the app dispatcher: controller command codes, FSM states,
// read-tag layout and the round-robin pick helpers.
package mp_app_dispatch_pkg;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;
   localparam int TAG_ADX_MAX_W = 32;

   typedef enum logic [1:0] {S_IDLE, S_WR_DATA, S_WR_CMD, S_RD_CMD} state_e;

   typedef struct packed {
      logic [1:0]               port;
      logic [TAG_ADX_MAX_W-1:0] adx;
   } tag_t;

   // First set bit of elig at or after ptr (wrapping at n); result is {found, index}.
   function automatic logic [3:0] rr_pick(input logic [7:0] elig, input logic [2:0] ptr, input int n);
      logic [3:0] res;
      int idx;
      res = '0;
      for (int i = 7; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= n) idx = idx - n;
         if (i < n && elig[idx[2:0]]) res = {1'b1, idx[2:0]};
      end
      return res;
   endfunction

   function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
      return (int'(idx) + 1 >= n) ? 3'd0 : idx + 3'd1;
   endfunction

endpackage

// File: rtl/mp_app_dispatch_if.sv
// Requester-side and memory-controller-side signals of the dispatcher.
// slave = the dispatcher's view, master = the surrounding system's view.
interface mp_app_dispatch_if #(
   parameter int NUM_PORTS  = 2,
   parameter int ADX_W      = 27,
   parameter int REQ_DATA_W = 128,
   parameter int APP_DATA_W = 64
);
   logic                                 init_calib_complete;
   logic [NUM_PORTS-1:0]                 port_wr_req, port_rd_req;
   logic [NUM_PORTS-1:0][ADX_W-1:0]      port_wr_adx, port_rd_adx;
   logic [NUM_PORTS-1:0][REQ_DATA_W-1:0] port_wr_data;
   logic [NUM_PORTS-1:0]                 port_wr_ack, port_rd_ack;
   logic                                 rd_valid;
   logic [REQ_DATA_W-1:0]                rd_data;
   logic [ADX_W-1:0]                     rd_adx;
   logic [1:0]                           rd_port;
   logic [ADX_W-1:0]                     app_addr;
   logic [2:0]                           app_cmd;
   logic                                 app_en, app_rdy;
   logic [APP_DATA_W-1:0]                app_wdf_data;
   logic                                 app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic [APP_DATA_W-1:0]                app_rd_data;
   logic                                 app_rd_data_valid, app_rd_data_end;

   modport slave (
      input  init_calib_complete, port_wr_req, port_rd_req, port_wr_adx, port_rd_adx, port_wr_data,
             app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
      output port_wr_ack, port_rd_ack, rd_valid, rd_data, rd_adx, rd_port,
             app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end
   );

   modport master (
      output init_calib_complete, port_wr_req, port_rd_req, port_wr_adx, port_rd_adx, port_wr_data,
             app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
      input  port_wr_ack, port_rd_ack, rd_valid, rd_data, rd_adx, rd_port,
             app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end
   );
endinterface

// File: rtl/mp_app_dispatch_tag_fifo.sv
// Outstanding-read tag FIFO; push and pop may coincide at any occupancy.
module dispatch_tag_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 29
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i && !empty_o;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || pop_i);
   assign dout_o  = mem[rptr_q];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= din_i;
   end
endmodule

// File: rtl/mp_app_dispatch.sv
// Multi-port arbiter/dispatcher onto a memory-controller app interface with tagged read return.
// Build option APP_DISPATCH_WR_PRIORITY_EN: writes beat reads, separate round-robins per class.
module mp_app_dispatch
   import mp_app_dispatch_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int ADX_W      = 27,
   parameter int REQ_DATA_W = 128,
   parameter int APP_DATA_W = 64,
   parameter int TAG_DEPTH  = 8
) (
   input logic              clk,
   input logic              resetn,
   mp_app_dispatch_if.slave bus
);
   localparam int NR    = 2 * NUM_PORTS;
   localparam int BEATS = REQ_DATA_W / APP_DATA_W;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TW    = 2 + ADX_W;
   localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

   state_e                state_q, state_d;
   logic [NR-1:0]         elig;
   logic [3:0]            pick;
   logic                  gnt_vld;
   logic [2:0]            gnt_r;
   logic [ADX_W-1:0]      g_adx, adx_q, rd_adx_q;
   logic [REQ_DATA_W-1:0] g_data, wdata_q, rdata_q;
   logic [1:0]            port_q, rd_port_q;
   logic [BW-1:0]         wbeat_q, rbeat_q;
   logic                  rd_valid_q;
   logic                  tag_push, tag_pop, tag_full, tag_empty;
   logic [TW-1:0]         tag_dout;
   tag_t                  head;

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         elig[2*p]   = resetn && bus.init_calib_complete && state_q == S_IDLE && bus.port_wr_req[p];
         elig[2*p+1] = resetn && bus.init_calib_complete && state_q == S_IDLE && bus.port_rd_req[p]
                       && !tag_full;
      end
   end

`ifdef APP_DISPATCH_WR_PRIORITY_EN
   logic [2:0]           wptr_q, rptr_q;
   logic [NUM_PORTS-1:0] welig, relig;
   logic [3:0]           wpick, rpick;

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         welig[p] = elig[2*p];
         relig[p] = elig[2*p+1];
      end
      wpick = rr_pick(8'(welig), wptr_q, NUM_PORTS);
      rpick = rr_pick(8'(relig), rptr_q, NUM_PORTS);
      pick  = wpick[3] ? {1'b1, wpick[1:0], 1'b0} : {rpick[3], rpick[1:0], 1'b1};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else if (pick[3]) begin
         if (pick[0]) rptr_q <= rr_next({1'b0, pick[2:1]}, NUM_PORTS);
         else         wptr_q <= rr_next({1'b0, pick[2:1]}, NUM_PORTS);
      end
   end
`else
   logic [2:0] ptr_q;

   always_comb pick = rr_pick(8'(elig), ptr_q, NR);

   always_ff @(posedge clk) begin
      if (!resetn)      ptr_q <= '0;
      else if (pick[3]) ptr_q <= rr_next(pick[2:0], NR);
   end
`endif

   assign gnt_vld = pick[3];
   assign gnt_r   = pick[2:0];

   always_comb begin
      g_adx  = '0;
      g_data = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt_r[2:1] == 2'(p)) begin
            g_adx  = gnt_r[0] ? bus.port_rd_adx[p] : bus.port_wr_adx[p];
            g_data = bus.port_wr_data[p];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (gnt_vld) state_d = gnt_r[0] ? S_RD_CMD : S_WR_DATA;
         S_WR_DATA: if (bus.app_wdf_rdy && wbeat_q == LAST) state_d = S_WR_CMD;
         S_WR_CMD:  if (bus.app_rdy) state_d = S_IDLE;
         S_RD_CMD:  if (bus.app_rdy) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.port_wr_ack  = '0;
      bus.port_rd_ack  = '0;
      bus.app_en       = 1'b0;
      bus.app_cmd      = CMD_WR;
      bus.app_addr     = '0;
      bus.app_wdf_data = '0;
      bus.app_wdf_wren = 1'b0;
      bus.app_wdf_end  = 1'b0;
      tag_push         = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         bus.port_wr_ack[p] = gnt_vld && gnt_r == 3'(2*p);
         bus.port_rd_ack[p] = gnt_vld && gnt_r == 3'(2*p+1);
      end
      case (state_q)
         S_WR_DATA: begin
            bus.app_wdf_wren = 1'b1;
            bus.app_wdf_data = wdata_q[APP_DATA_W-1:0];
            bus.app_wdf_end  = (wbeat_q == LAST);
         end
         S_WR_CMD: begin
            bus.app_en   = 1'b1;
            bus.app_addr = adx_q;
         end
         S_RD_CMD: begin
            bus.app_en   = 1'b1;
            bus.app_cmd  = CMD_RD;
            bus.app_addr = adx_q;
            tag_push     = bus.app_rdy;
         end
         default: ;
      endcase
   end

   // Write data sits in a shift register so the current beat is always the low slice.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         adx_q   <= '0;
         port_q  <= '0;
         wdata_q <= '0;
         wbeat_q <= '0;
      end else if (gnt_vld) begin
         adx_q   <= g_adx;
         port_q  <= gnt_r[2:1];
         wdata_q <= g_data;
         wbeat_q <= '0;
      end else if (state_q == S_WR_DATA && bus.app_wdf_rdy) begin
         wdata_q <= wdata_q >> APP_DATA_W;
         wbeat_q <= (wbeat_q == LAST) ? '0 : wbeat_q + 1'b1;
      end
   end

   dispatch_tag_fifo #(.DEPTH(TAG_DEPTH), .W(TW)) u_tags (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (tag_push),
      .din_i   ({port_q, adx_q}),
      .pop_i   (tag_pop),
      .dout_o  (tag_dout),
      .full_o  (tag_full),
      .empty_o (tag_empty)
   );

   always_comb begin
      head.port = tag_dout[TW-1 -: 2];
      head.adx  = TAG_ADX_MAX_W'(tag_dout[ADX_W-1:0]);
   end

   assign tag_pop = bus.app_rd_data_valid && !tag_empty && rbeat_q == LAST;

   // Beats with no outstanding tag are strays and are ignored entirely.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rbeat_q    <= '0;
         rdata_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_port_q  <= '0;
         rd_adx_q   <= '0;
      end else begin
         rd_valid_q <= 1'b0;
         if (bus.app_rd_data_valid && !tag_empty) begin
            for (int k = 0; k < BEATS; k++)
               if (rbeat_q == BW'(k)) rdata_q[k*APP_DATA_W +: APP_DATA_W] <= bus.app_rd_data;
            if (rbeat_q == LAST) begin
               rbeat_q    <= '0;
               rd_valid_q <= 1'b1;
               rd_port_q  <= head.port;
               rd_adx_q   <= head.adx[ADX_W-1:0];
            end else begin
               rbeat_q <= rbeat_q + 1'b1;
            end
         end
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rdata_q;
   assign bus.rd_port  = rd_port_q;
   assign bus.rd_adx   = rd_adx_q;
endmodule
